// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
//   Types and constants shared by all elastic pipeline stage registers.
//   pipe_state_t : fill state of a two-entry skid stage.
//   PIPE_OCC_W   : width of the occupancy count (0..2 entries).
// ---------------------------------------------------------------------------
package pipe_pkg;

    localparam int PIPE_OCC_W = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

endpackage : pipe_pkg

// File: rtl/pipe_sat_counter.sv
// ---------------------------------------------------------------------------
// pipe_sat_counter
//   Up-counter that sticks at all-ones instead of wrapping.
//   Ports:
//     clk    in   clock, rising edge
//     reset  in   asynchronous, active-low; clears count
//     inc    in   count this cycle
//     count  out  CNT_W-bit saturating count (registered)
// ---------------------------------------------------------------------------
module pipe_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule : pipe_sat_counter

// File: rtl/pipe_skid_reg.sv
// ---------------------------------------------------------------------------
// pipe_skid_reg
//   Two-entry elastic pipeline register with valid/ready on both sides.
//   A downstream stall never drops or duplicates a word; flush kills both
//   entries synchronously. One instance per CPU pipeline boundary.
//   Optional feature: define PIPE_SKID_PERF_EN to add the CNT_W parameter,
//   the stall_cnt port and its saturating counter.
//   Ports:
//     clk        in   clock, rising edge
//     reset      in   asynchronous, active-low
//     flush      in   synchronous kill of both entries
//     in_valid   in   upstream has data
//     in_ready   out  stage can accept (registered)
//     in_data    in   WIDTH upstream payload
//     out_valid  out  out_data valid (registered)
//     out_ready  in   downstream accepts
//     out_data   out  WIDTH payload of oldest entry (registered)
//     occupancy  out  entries held 0..2 (registered)
//     stall_cnt  out  CNT_W cycles with out_valid && !out_ready (macro only)
// ---------------------------------------------------------------------------
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
`ifdef PIPE_SKID_PERF_EN
    ,
    parameter int               CNT_W     = 16
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [PIPE_OCC_W-1:0] occupancy
`ifdef PIPE_SKID_PERF_EN
    ,
    output logic [CNT_W-1:0]      stall_cnt
`endif
);

    pipe_state_t           state_q, state_d;
    logic [WIDTH-1:0]      main_q, main_d;
    logic [WIDTH-1:0]      skid_q, skid_d;
    logic                  out_valid_q, out_valid_d;
    logic                  in_ready_q, in_ready_d;
    logic [PIPE_OCC_W-1:0] occ_q, occ_d;

    logic push;
    logic pop;

    // Handshakes use only registered in_ready/out_valid, so out_ready never
    // reaches in_ready combinationally.
    assign push = in_valid && in_ready_q;
    assign pop  = out_valid_q && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        unique case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d = ONE;
                    main_d  = in_data;
                end
            end
            ONE: begin
                if (push && !pop) begin
                    state_d = FULL;
                    skid_d  = in_data;
                end else if (push && pop) begin
                    main_d  = in_data;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so only a pop can happen.
                if (pop) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase

        // Flush wins over any push/pop; data flops may keep stale words.
        if (flush) begin
            state_d = EMPTY;
        end

        // Status outputs are precomputed from next state so they leave flops.
        out_valid_d = (state_d != EMPTY);
        in_ready_d  = (state_d != FULL);
        occ_d       = state_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= EMPTY;
            main_q      <= RESET_VAL;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            occ_q       <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            occ_q       <= occ_d;
        end
    end

    // Skid entry is only read while FULL, so it needs no reset.
    always_ff @(posedge clk) begin
        skid_q <= skid_d;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign occupancy = occ_q;

`ifdef PIPE_SKID_PERF_EN
    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (out_valid_q && !out_ready),
        .count (stall_cnt)
    );
`endif

endmodule : pipe_skid_reg
